// File: rtl/xoodyak_absorb_packer_if.sv
// Message-side and block-side signals of the Xoodyak absorb packer.
// master = message source / block consumer, slave = the packer itself.
interface xoodyak_absorb_packer_if #(
    parameter int unsigned RATE_BYTES = 16,
    parameter int unsigned LEN_W      = 12
);
    logic                          start;
    logic [LEN_W-1:0]              msg_len;
    logic                          load;
    logic [7:0]                    msg;
    logic                          in_ready;
    logic                          blk_valid;
    logic                          blk_ready;
    logic [8*(RATE_BYTES+1)-1:0]   blk_data;
    logic [4:0]                    blk_len;
    logic                          blk_first;
    logic                          blk_last;
    logic                          busy;
    logic                          ovf;

    modport master (
        output start, msg_len, load, msg, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_len, blk_first, blk_last, busy, ovf
    );

    modport slave (
        input  start, msg_len, load, msg, blk_ready,
        output in_ready, blk_valid, blk_data, blk_len, blk_first, blk_last, busy, ovf
    );
endinterface

// File: rtl/xoodyak_absorb_packer.sv
// Packs a byte stream into padded Xoodyak absorb blocks held in a two-entry
// ping-pong buffer, handed downstream over a valid/ready handshake.
module xoodyak_absorb_packer #(
    parameter int unsigned RATE_BYTES = 16,
    parameter int unsigned LEN_W      = 12
) (
    input logic                    clk,
    input logic                    resetn,
    xoodyak_absorb_packer_if.slave bus
);
    localparam int unsigned BlkW = 8 * (RATE_BYTES + 1);
    localparam int unsigned IdxW = 5;

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e           state_q, state_d;
    logic [BlkW-1:0]  buf_data_q [2];
    logic [BlkW-1:0]  buf_data_d [2];
    logic [IdxW-1:0]  buf_len_q  [2];
    logic [IdxW-1:0]  buf_len_d  [2];
    logic [1:0]       buf_full_q, buf_full_d;
    logic [1:0]       buf_first_q, buf_first_d;
    logic [1:0]       buf_last_q, buf_last_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             accept;
    logic             close_blk;
    logic             pop;
    logic             blk_valid;
    logic [IdxW-1:0]  idx_inc;

    assign in_ready  = (state_q == StFill) && !buf_full_q[wr_ptr_q];
    assign accept    = bus.load && in_ready;
    assign idx_inc   = idx_q + 1'b1;
    assign close_blk = accept && ((idx_inc == IdxW'(RATE_BYTES)) || (rem_q == LEN_W'(1)));
    assign blk_valid = buf_full_q[rd_ptr_q];
    assign pop       = blk_valid && bus.blk_ready;

    always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        buf_len_d   = buf_len_q;
        buf_full_d  = buf_full_q;
        buf_first_d = buf_first_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        first_d     = first_q;
        ovf_d       = ovf_q;

        // Pop and close always hit different buffers: a close needs the write buffer free.
        if (pop) begin
            buf_full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = ~rd_ptr_q;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ovf_d = 1'b0;
                    if (bus.msg_len == '0) begin
                        buf_data_d[wr_ptr_q]  = BlkW'(8'h01);
                        buf_len_d[wr_ptr_q]   = '0;
                        buf_full_d[wr_ptr_q]  = 1'b1;
                        buf_first_d[wr_ptr_q] = 1'b1;
                        buf_last_d[wr_ptr_q]  = 1'b1;
                        wr_ptr_d              = ~wr_ptr_q;
                        state_d               = StDrain;
                    end else begin
                        rem_d   = bus.msg_len;
                        idx_d   = '0;
                        first_d = 1'b1;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (accept) begin
                    // First byte of a block wipes stale contents so the tail reads as zero.
                    if (idx_q == '0) buf_data_d[wr_ptr_q] = '0;
                    for (int unsigned k = 0; k <= RATE_BYTES; k++) begin
                        if (IdxW'(k) == idx_q) buf_data_d[wr_ptr_q][8*k +: 8] = bus.msg;
                        if (close_blk && (IdxW'(k) == idx_inc)) begin
                            buf_data_d[wr_ptr_q][8*k +: 8] = 8'h01;
                        end
                    end
                    idx_d = idx_inc;
                    rem_d = rem_q - 1'b1;
                    if (close_blk) begin
                        buf_len_d[wr_ptr_q]   = idx_inc;
                        buf_full_d[wr_ptr_q]  = 1'b1;
                        buf_first_d[wr_ptr_q] = first_q;
                        buf_last_d[wr_ptr_q]  = (rem_q == LEN_W'(1));
                        wr_ptr_d              = ~wr_ptr_q;
                        idx_d                 = '0;
                        first_d               = 1'b0;
                        if (rem_q == LEN_W'(1)) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (buf_full_q == 2'b00) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.load && !in_ready) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            buf_data_q  <= '{default: '0};
            buf_len_q   <= '{default: '0};
            buf_full_q  <= '0;
            buf_first_q <= '0;
            buf_last_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            idx_q       <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_data_q  <= buf_data_d;
            buf_len_q   <= buf_len_d;
            buf_full_q  <= buf_full_d;
            buf_first_q <= buf_first_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.blk_valid = blk_valid;
    assign bus.blk_data  = blk_valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.blk_len   = blk_valid ? buf_len_q[rd_ptr_q] : '0;
    assign bus.blk_first = blk_valid && buf_first_q[rd_ptr_q];
    assign bus.blk_last  = blk_valid && buf_last_q[rd_ptr_q];
    assign bus.busy      = (state_q != StIdle);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_xoodyak_absorb_packer.sv
// Scoreboard bench for xoodyak_absorb_packer: stimulus pushes expected blocks,
// an independent monitor pops and compares on every accepted block.
module tb_xoodyak_absorb_packer;
    logic clk;
    logic resetn;

    xoodyak_absorb_packer_if #(.RATE_BYTES(16), .LEN_W(12)) bus ();

    xoodyak_absorb_packer #(.RATE_BYTES(16), .LEN_W(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [135:0] data;
        logic [4:0]   len;
        logic         first;
        logic         last;
    } blk_t;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rx     = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: a block is consumed at the posedge following a negedge with valid&&ready.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (resetn && bus.blk_valid && bus.blk_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_block: got len %0d data %h, want no block",
                             bus.blk_len, bus.blk_data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", bus.blk_data, e.data);
                    check("blk_len_first_last", {bus.blk_len, bus.blk_first, bus.blk_last},
                          {e.len, e.first, e.last});
                end
            end
        end
    end

    initial begin
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.blk_ready = 1'b1;
                1:       bus.blk_ready = 1'b0;
                default: bus.blk_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference packing of the pattern message byte i = i & 0xFF.
    task automatic push_model(input int len);
        int nblk = (len == 0) ? 1 : (len + 15) / 16;
        for (int b = 0; b < nblk; b++) begin
            blk_t e;
            int   blen = (len - 16 * b > 16) ? 16 : len - 16 * b;
            e.data = '0;
            for (int j = 0; j < blen; j++) e.data[8*j +: 8] = 8'((16 * b + j) & 8'hFF);
            e.data[8*blen +: 8] = 8'h01;
            e.len   = 5'(blen);
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.msg_len = 12'(len);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            check("in_ready_timeout", 1'b0, 1'b1);
        end else begin
            bus.load = 1'b1;
            bus.msg  = b;
            @(posedge clk);
            #1;
            bus.load = 1'b0;
        end
    endtask

    task automatic send_bytes(input int first, input int count);
        for (int i = first; i < first + count; i++) send_byte(8'(i & 8'hFF));
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (exp_q.size() == 0 && !bus.busy), 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_blk_valid"}, bus.blk_valid, 1'b0);
        check({tag, "_blk_data"}, bus.blk_data, '0);
        check({tag, "_len_first_last"}, {bus.blk_len, bus.blk_first, bus.blk_last}, '0);
        check({tag, "_busy_ovf"}, {bus.busy, bus.ovf}, 2'b00);
    endtask

    initial begin
        blk_t e;
        int   rx0;
        bus.start   = 1'b0;
        bus.msg_len = '0;
        bus.load    = 1'b0;
        bus.msg     = '0;
        resetn      = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;

        // 19 bytes: hand-computed blocks.
        e.data = {8'h01, 128'h0F0E0D0C0B0A09080706050403020100};
        e.len = 5'd16; e.first = 1'b1; e.last = 1'b0;
        exp_q.push_back(e);
        e.data = 136'h01121110;
        e.len = 5'd3; e.first = 1'b0; e.last = 1'b1;
        exp_q.push_back(e);
        do_start(19);
        @(negedge clk);
        check("busy_after_start", bus.busy, 1'b1);
        send_bytes(0, 18);
        send_bytes(18, 1);
        wait_drain();

        // Empty message.
        e.data = 136'h01; e.len = 5'd0; e.first = 1'b1; e.last = 1'b1;
        exp_q.push_back(e);
        do_start(0);
        wait_drain();
        check("busy_after_empty", bus.busy, 1'b0);

        // 32 bytes with consumer stalled: both buffers fill, then in_ready drops.
        rdy_mode = 1;
        rx0 = n_rx;
        push_model(32);
        do_start(32);
        send_bytes(0, 32);
        @(negedge clk);
        check("in_ready_full", bus.in_ready, 1'b0);
        check("valid_busy_stalled", {bus.blk_valid, bus.busy, bus.ovf}, 3'b110);
        bus.load = 1'b1;
        bus.msg  = 8'hEE;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        @(negedge clk);
        check("ovf_on_drop", bus.ovf, 1'b1);
        rdy_mode = 0;
        wait_drain();
        check("blocks_32", n_rx - rx0, 2);
        check("ovf_sticky_idle", bus.ovf, 1'b1);

        // 1024 bytes with random back-pressure; start must clear ovf.
        rdy_mode = 2;
        rx0 = n_rx;
        push_model(1024);
        do_start(1024);
        @(negedge clk);
        check("ovf_cleared_by_start", bus.ovf, 1'b0);
        send_bytes(0, 1024);
        wait_drain();
        check("blocks_1024", n_rx - rx0, 64);
        rdy_mode = 0;

        // Async reset mid-message, then a fresh message.
        do_start(19);
        send_bytes(0, 10);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        resetn = 1'b1;
        rx0 = n_rx;
        push_model(19);
        do_start(19);
        send_bytes(0, 19);
        wait_drain();
        check("blocks_after_reset", n_rx - rx0, 2);

        // Load while idle is dropped and flags ovf.
        rx0 = n_rx;
        @(negedge clk);
        bus.load = 1'b1;
        bus.msg  = 8'h55;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_idle_load", {bus.ovf, bus.busy, bus.blk_valid}, 3'b100);
        check("no_block_from_idle_load", n_rx - rx0, 0);

        push_model(1);
        do_start(1);
        @(negedge clk);
        check("ovf_cleared_again", bus.ovf, 1'b0);
        send_bytes(0, 1);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
